// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the program/data memory port arbiter.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 8;
    localparam int ARB_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CU   = 1'b0,
        OWN_HOST = 1'b1
    } arb_owner_t;

    // Width of the streak counter; a zero limit still needs one storage bit.
    function automatic int starve_w(input int limit);
        if (limit > 0) begin
            return $clog2(limit + 1);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive CU grants taken while HOST was waiting.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 3
)(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    input  logic freeze,
    output logic at_limit
);

    localparam int CW = starve_w(LIMIT);
    localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);

    logic [CW-1:0] count_r;

    // Streak register: freeze beats clear, clear beats increment, increment saturates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (freeze) begin
            count_r <= count_r;
        end else if (clear) begin
            count_r <= '0;
        end else if (inc && (count_r != LIMIT_V)) begin
            count_r <= count_r + CW'(1);
        end
    end

    assign at_limit = (LIMIT != 0) && (count_r == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (CU/HOST) arbiter for the single-port memory: IDLE->ISSUE->WAIT->DONE.
// Optional host_lock input is compiled in with ARB_HOST_LOCK_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 3
)(
    input  logic              clock,
    input  logic              reset,
`ifdef ARB_HOST_LOCK_EN
    input  logic              host_lock,
`endif
    input  logic              cu_req,
    input  logic              cu_we,
    input  logic [ADDR_W-1:0] cu_addr,
    input  logic [DATA_W-1:0] cu_wdata,
    output logic              cu_ack,
    output logic [DATA_W-1:0] cu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int WCW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_LATENCY - 1);

    arb_state_t        state_r;
    arb_state_t        state_s;
    arb_owner_t        owner_r;
    logic              we_r;
    logic [WCW-1:0]    wait_cnt_r;
    logic              wait_last_s;
    logic              lock_s;
    logic              at_limit_s;
    logic              cu_grant_s;
    logic              host_grant_s;
    logic              grant_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              streak_clear_s;
    logic              streak_inc_s;

`ifdef ARB_HOST_LOCK_EN
    assign lock_s = host_lock;
`else
    assign lock_s = 1'b0;
`endif

    assign wait_last_s = (wait_cnt_r == WAIT_LAST);
    assign grant_s     = cu_grant_s | host_grant_s;

    // Next-state and grant decision; CU wins unless HOST has hit the streak limit or the lock is set.
    always_comb begin
        state_s      = state_r;
        cu_grant_s   = 1'b0;
        host_grant_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cu_req && !lock_s && !(host_req && at_limit_s)) begin
                    cu_grant_s = 1'b1;
                    state_s    = ST_ISSUE;
                end else if (host_req) begin
                    host_grant_s = 1'b1;
                    state_s      = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Request mux feeding the captured access registers.
    always_comb begin
        sel_we_s    = cu_we;
        sel_addr_s  = cu_addr;
        sel_wdata_s = cu_wdata;
        if (host_grant_s) begin
            sel_we_s    = host_we;
            sel_addr_s  = host_addr;
            sel_wdata_s = host_wdata;
        end else begin
            sel_we_s    = cu_we;
            sel_addr_s  = cu_addr;
            sel_wdata_s = cu_wdata;
        end
    end

    // Streak only evolves on IDLE decisions; a HOST grant or an absent HOST request restarts it.
    always_comb begin
        streak_clear_s = 1'b0;
        streak_inc_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            streak_clear_s = host_grant_s | ~host_req;
            streak_inc_s   = cu_grant_s & host_req;
        end else begin
            streak_clear_s = 1'b0;
            streak_inc_s   = 1'b0;
        end
    end

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clock    (clock),
        .reset    (reset),
        .clear    (streak_clear_s),
        .inc      (streak_inc_s),
        .freeze   (lock_s),
        .at_limit (at_limit_s)
    );

    // Sequencer state, captured access, memory strobes, acks and per-requester read data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            owner_r    <= OWN_CU;
            we_r       <= 1'b0;
            wait_cnt_r <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            cu_ack     <= 1'b0;
            host_ack   <= 1'b0;
            cu_rdata   <= '0;
            host_rdata <= '0;
        end else begin
            state_r <= state_s;
            if (grant_s) begin
                owner_r   <= host_grant_s ? OWN_HOST : OWN_CU;
                we_r      <= sel_we_s;
                mem_addr  <= sel_addr_s;
                mem_wdata <= sel_wdata_s;
            end
            mem_en <= grant_s;
            mem_we <= grant_s & sel_we_s;
            busy   <= (state_s != ST_IDLE);
            if ((state_r == ST_WAIT) && !wait_last_s) begin
                wait_cnt_r <= wait_cnt_r + WCW'(1);
            end else begin
                wait_cnt_r <= '0;
            end
            cu_ack   <= (state_s == ST_DONE) && (owner_r == OWN_CU);
            host_ack <= (state_s == ST_DONE) && (owner_r == OWN_HOST);
            // Read data lands on the edge that closes the final WAIT cycle.
            if ((state_r == ST_WAIT) && wait_last_s && !we_r) begin
                if (owner_r == OWN_HOST) begin
                    host_rdata <= mem_rdata;
                end else begin
                    cu_rdata <= mem_rdata;
                end
            end
        end
    end

    assign owner = owner_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural MEM_LATENCY=1 memory.
module tb_mem_port_arbiter;

    logic       clock;
    logic       reset;
    logic       cu_req, cu_we, host_req, host_we;
    logic [7:0] cu_addr, cu_wdata, host_addr, host_wdata;
    logic       cu_ack, host_ack, mem_en, mem_we, busy, owner;
    logic [7:0] cu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_HOST_LOCK_EN
    logic       host_lock;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; } acc_t;
    typedef struct { logic host; logic [7:0] cu_rd; logic [7:0] host_rd; } ack_t;
    acc_t acc_q[$];
    ack_t ack_q[$];
    logic [7:0] model_cu_rd, model_host_rd;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
`ifdef ARB_HOST_LOCK_EN
        .host_lock(host_lock),
`endif
        .cu_req(cu_req), .cu_we(cu_we), .cu_addr(cu_addr), .cu_wdata(cu_wdata),
        .cu_ack(cu_ack), .cu_rdata(cu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model, preloaded on the first edge (during reset).
    logic [7:0] mem [256];
    bit loaded = 1'b0;
    always @(posedge clock) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h05] <= 8'h5A;
            mem[8'h10] <= 8'hA5;
            mem[8'h11] <= 8'h77;
            mem[8'h12] <= 8'h99;
            mem_rdata  <= 8'h00;
            loaded     <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected access and ack, pushed in the hand-derived grant order.
    task automatic expect_txn(input logic host, input logic we, input logic [7:0] addr,
                              input logic [7:0] wdata, input logic [7:0] rd);
        acc_t a;
        ack_t k;
        a.we = we; a.addr = addr; a.wdata = wdata;
        acc_q.push_back(a);
        if (!we) begin
            if (host) model_host_rd = rd;
            else      model_cu_rd   = rd;
        end
        k.host = host; k.cu_rd = model_cu_rd; k.host_rd = model_host_rd;
        ack_q.push_back(k);
    endtask

    // Monitor: pops on every memory strobe and every ack.
    always @(negedge clock) begin
        if (reset) begin
            if (mem_en) begin
                if (acc_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_access actual=addr %0h expected=none", mem_addr);
                end else begin
                    acc_t a;
                    a = acc_q.pop_front();
                    check("acc_we", 32'(mem_we), 32'(a.we));
                    check("acc_addr", 32'(mem_addr), 32'(a.addr));
                    if (a.we) check("acc_wdata", 32'(mem_wdata), 32'(a.wdata));
                end
            end
            if (cu_ack || host_ack) begin
                if (ack_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack actual=cu%0d host%0d expected=none", cu_ack, host_ack);
                end else begin
                    ack_t k;
                    k = ack_q.pop_front();
                    check("ack_host", 32'(host_ack), 32'(k.host));
                    check("ack_cu", 32'(cu_ack), 32'(!k.host));
                    check("ack_owner", 32'(owner), 32'(k.host));
                    check("cu_rdata", 32'(cu_rdata), 32'(k.cu_rd));
                    check("host_rdata", 32'(host_rdata), 32'(k.host_rd));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Count cycles until the chosen ack appears; a timeout yields a count mismatch.
    task automatic wait_ack(input bit host, input int exp_n, input string name);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 16) begin
            tick();
            n++;
            seen = host ? host_ack : cu_ack;
        end
        check(name, 32'(n), 32'(exp_n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        cu_req = 1'b0; cu_we = 1'b0; cu_addr = 8'h00; cu_wdata = 8'h00;
        host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
`ifdef ARB_HOST_LOCK_EN
        host_lock = 1'b0;
`endif
        model_cu_rd = 8'h00; model_host_rd = 8'h00;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_acks", 32'({cu_ack, host_ack, mem_we}), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_rdata", 32'({cu_rdata, host_rdata, mem_addr, mem_wdata}), 32'd0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();

        // CU read of 0x10 with exact strobe and ack timing.
        expect_txn(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
        cu_req = 1'b1; cu_we = 1'b0; cu_addr = 8'h10;
        tick();
        check("t1_en_c1", 32'({mem_en, mem_we, busy}), 32'b101);
        check("t1_addr_c1", 32'(mem_addr), 32'h10);
        tick();
        check("t1_en_c2", 32'(mem_en), 32'd0);
        wait_ack(1'b0, 1, "t1_ack_c3");
        cu_req = 1'b0;
        repeat (2) tick();

        // Simultaneous requests: CU first, HOST four cycles after CU's ack.
        expect_txn(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
        expect_txn(1'b1, 1'b0, 8'h11, 8'h00, 8'h77);
        cu_req = 1'b1; cu_addr = 8'h10;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h11;
        wait_ack(1'b0, 3, "t2_cu_ack");
        cu_req = 1'b0;
        wait_ack(1'b1, 4, "t2_host_ack");
        host_req = 1'b0;
        repeat (2) tick();

        // Starvation limit 3: CU held high gives CU, CU, CU, HOST, CU.
        expect_txn(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
        expect_txn(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
        expect_txn(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
        expect_txn(1'b1, 1'b0, 8'h11, 8'h00, 8'h77);
        expect_txn(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
        cu_req = 1'b1; host_req = 1'b1;
        wait_ack(1'b0, 3, "t3_cu1");
        wait_ack(1'b0, 4, "t3_cu2");
        wait_ack(1'b0, 4, "t3_cu3");
        wait_ack(1'b1, 4, "t3_host");
        host_req = 1'b0;
        wait_ack(1'b0, 4, "t3_cu4");
        cu_req = 1'b0;
        repeat (2) tick();

        // HOST writes 0x3C to 0x20, then CU reads it back.
        expect_txn(1'b1, 1'b1, 8'h20, 8'h3C, 8'h00);
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'h3C;
        wait_ack(1'b1, 3, "t4_host_wr");
        host_req = 1'b0; host_we = 1'b0;
        tick();
        expect_txn(1'b0, 1'b0, 8'h20, 8'h00, 8'h3C);
        cu_req = 1'b1; cu_addr = 8'h20;
        wait_ack(1'b0, 3, "t4_cu_rd");
        cu_req = 1'b0;
        repeat (2) tick();

        // Reset during WAIT of a CU read: no ack, then a clean transaction.
        begin
            acc_t a;
            a.we = 1'b0; a.addr = 8'h12; a.wdata = 8'h00;
            acc_q.push_back(a);
        end
        cu_req = 1'b1; cu_addr = 8'h12;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_en_ack", 32'({mem_en, cu_ack}), 32'd0);
        check("t5_cu_rdata", 32'(cu_rdata), 32'd0);
        model_cu_rd = 8'h00; model_host_rd = 8'h00;
        cu_req = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("t5_idle", 32'(busy), 32'd0);
        expect_txn(1'b0, 1'b0, 8'h12, 8'h00, 8'h99);
        cu_req = 1'b1;
        wait_ack(1'b0, 3, "t5_cu_after");
        cu_req = 1'b0;
        repeat (2) tick();

`ifdef ARB_HOST_LOCK_EN
        // Lock blocks CU for 20 cycles; HOST still served; release grants CU.
        host_lock = 1'b1;
        cu_req = 1'b1; cu_addr = 8'h10;
        repeat (20) tick();
        check("t6_locked_busy", 32'(busy), 32'd0);
        expect_txn(1'b1, 1'b0, 8'h05, 8'h00, 8'h5A);
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
        wait_ack(1'b1, 3, "t6_host");
        host_req = 1'b0;
        expect_txn(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
        host_lock = 1'b0;
        wait_ack(1'b0, 4, "t6_cu_release");
        cu_req = 1'b0;
        repeat (2) tick();
`endif

        check("acc_q_empty", 32'(acc_q.size()), 32'd0);
        check("ack_q_empty", 32'(ack_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
